usb_host_linectl: RTL

USB_HOST_LINECTL -- requirements
Module: usb_host_linectl

---
 rtl/usb_host_linectl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/usb_host_linectl.sv
// USB host line controller: drives bus reset (SE0), resume (K) and
// keep-alive EOP (SE0 then J) onto the pads, and tracks device attach from
// the synchronized receive levels.
module usb_host_linectl #(
  parameter int unsigned RESET_CLKS   = 480000,
  parameter int unsigned RESUME_CLKS  = 960000,
  parameter int unsigned EOP_SE0_CLKS = 8,
  parameter int unsigned EOP_J_CLKS   = 4,
  parameter int unsigned CONNECT_CLKS = 4800,
  parameter int unsigned DISC_CLKS    = 120
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_tx_en,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  output logic       connected
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_SE0,
    ST_RES_K,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_DONE
  } state_t;

  // Counters count down to zero, so each timed state is loaded with N-1.
  localparam logic [31:0] RESET_LD   = 32'(RESET_CLKS - 1);
  localparam logic [31:0] RESUME_LD  = 32'(RESUME_CLKS - 1);
  localparam logic [31:0] EOP_SE0_LD = 32'(EOP_SE0_CLKS - 1);
  localparam logic [31:0] EOP_J_LD   = 32'(EOP_J_CLKS - 1);
  localparam logic [31:0] CONN_MAX   = 32'(CONNECT_CLKS);
  localparam logic [31:0] DISC_MAX   = 32'(DISC_CLKS);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        p_tx_q, p_tx_d;
  logic        n_tx_q, n_tx_d;
  logic        tx_en_q, tx_en_d;

  logic        p_s1_q, p_s2_q, n_s1_q, n_s2_q;
  logic [31:0] jrun_q, jrun_d;
  logic [31:0] srun_q, srun_d;
  logic        conn_q, conn_d;
  logic        rx_j, rx_se0;

  // Next state and timer; a command is taken only while the registered ready is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          unique case (cmd_op)
            2'b00: begin state_d = ST_RST_SE0; cnt_d = RESET_LD;   end
            2'b01: begin state_d = ST_RES_K;   cnt_d = RESUME_LD;  end
            2'b10: begin state_d = ST_EOP_SE0; cnt_d = EOP_SE0_LD; end
            default: begin state_d = ST_DONE;  cnt_d = '0;         end
          endcase
        end
      end
      ST_RST_SE0: begin
        if (cnt_q == '0) begin state_d = ST_EOP_J; cnt_d = EOP_J_LD; end
        else cnt_d = cnt_q - 32'd1;
      end
      ST_RES_K: begin
        if (cnt_q == '0) begin state_d = ST_EOP_SE0; cnt_d = EOP_SE0_LD; end
        else cnt_d = cnt_q - 32'd1;
      end
      ST_EOP_SE0: begin
        if (cnt_q == '0) begin state_d = ST_EOP_J; cnt_d = EOP_J_LD; end
        else cnt_d = cnt_q - 32'd1;
      end
      ST_EOP_J: begin
        if (cnt_q == '0) begin state_d = ST_DONE; cnt_d = '0; end
        else cnt_d = cnt_q - 32'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state itself.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    p_tx_d      = 1'b1;
    n_tx_d      = 1'b0;
    tx_en_d     = 1'b0;
    unique case (state_d)
      ST_RST_SE0, ST_EOP_SE0: begin p_tx_d = 1'b0; n_tx_d = 1'b0; tx_en_d = 1'b1; end
      ST_RES_K:               begin p_tx_d = 1'b0; n_tx_d = 1'b1; tx_en_d = 1'b1; end
      ST_EOP_J:               begin p_tx_d = 1'b1; n_tx_d = 1'b0; tx_en_d = 1'b1; end
      default: ;
    endcase
  end

  // FSM state, timer and registered line/handshake outputs.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      p_tx_q      <= 1'b1;
      n_tx_q      <= 1'b0;
      tx_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      p_tx_q      <= p_tx_d;
      n_tx_q      <= n_tx_d;
      tx_en_q     <= tx_en_d;
    end
  end

  // Two-flop synchronizers for the asynchronous pad levels.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      p_s1_q <= 1'b0;
      p_s2_q <= 1'b0;
      n_s1_q <= 1'b0;
      n_s2_q <= 1'b0;
    end else begin
      p_s1_q <= usb_p_rx;
      p_s2_q <= p_s1_q;
      n_s1_q <= usb_n_rx;
      n_s2_q <= n_s1_q;
    end
  end

  assign rx_j   =  p_s2_q & ~n_s2_q;
  assign rx_se0 = ~p_s2_q & ~n_s2_q;

  // Run-length counters for idle J and SE0, only while the host is not driving.
  always_comb begin
    jrun_d = '0;
    srun_d = '0;
    if (!tx_en_q) begin
      if (rx_j)        jrun_d = (jrun_q >= CONN_MAX) ? jrun_q : jrun_q + 32'd1;
      else if (rx_se0) srun_d = (srun_q >= DISC_MAX) ? srun_q : srun_q + 32'd1;
    end
    conn_d = conn_q;
    if (jrun_q >= CONN_MAX)      conn_d = 1'b1;
    else if (srun_q >= DISC_MAX) conn_d = 1'b0;
  end

  // Attach status tracks the run counters one cycle after a threshold is hit.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      jrun_q <= '0;
      srun_q <= '0;
      conn_q <= 1'b0;
    end else begin
      jrun_q <= jrun_d;
      srun_q <= srun_d;
      conn_q <= conn_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign usb_p_tx  = p_tx_q;
  assign usb_n_tx  = n_tx_q;
  assign usb_tx_en = tx_en_q;
  assign connected = conn_q;

endmodule
